// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue/writeback slice: ALU Sel opcodes and
// controller state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// r0 is never written, so it reads as zero after reset.
module alu_regfile #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the registered ALU: one instruction
// in flight, load-immediates complete in a single cycle.
//
// state   | meaning
// IDLE    | ready; LD completes here, ALU op latches operands and goes to EXEC
// EXEC    | ALU registers its result; operands held stable
// WB      | capture alu_r into rf[rd] and pulse res_valid
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ld,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_z,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_q;
    logic              accept;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    // LD writes from the instruction port; WB writes the ALU result. They
    // can never coincide because WB is not a ready state.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = in_rd;
        rf_wdata = in_imm;
        if (accept && in_ld) begin
            rf_we = 1'b1;
        end else if (state == ST_WB) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_r;
        end
    end

    alu_regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS)
    ) u_rf (
        .CLK   (CLK),
        .RST   (RST),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr1(in_rs1),
        .rdata1(rs1_data),
        .raddr2(in_rs2),
        .rdata2(rs2_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && in_ld) begin
                        res_valid <= 1'b1;
                        res_rd    <= in_rd;
                        res_data  <= in_imm;
                        res_zero  <= (in_imm == '0);
                    end else if (accept) begin
                        alu_a   <= rs1_data;
                        alu_b   <= rs2_data;
                        alu_sel <= in_op;
                        rd_q    <= in_rd;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_WB;
                ST_WB: begin
                    res_valid <= 1'b1;
                    res_rd    <= rd_q;
                    res_data  <= alu_r;
                    res_zero  <= alu_z;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, register-file
// model and expected-result queue, directed scenarios then random traffic.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ld = 1'b0;
    logic [2:0]  in_op = '0;
    logic [2:0]  in_rd = '0;
    logic [2:0]  in_rs1 = '0;
    logic [2:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_r = '0;
    logic        alu_z;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [31:0] res_data;
    logic        res_zero;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  rd;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] rf_m[8];

    alu_issue_ctrl #(.DATA_W(32), .NREGS(8)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_r(alu_r), .alu_z(alu_z),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_zero(res_zero)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_MUL:  return a * b;
            OP_SUB:  return a - b;
            OP_SLT:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU standing in for the real one downstream of the DUT
    always @(posedge CLK) alu_r <= alu_fn(alu_sel, alu_a, alu_b);
    assign alu_z = (alu_r == 32'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && res_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("res_rd", {29'd0, res_rd}, {29'd0, e.rd});
                chk("res_data", res_data, e.data);
                chk("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;
        expq.delete();
    endtask

    task automatic send(input logic ld, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [31:0] imm, output int waited);
        logic [31:0] a_before, b_before, ea, eb, r;
        logic [2:0]  sel_before;
        exp_t        e;
        in_ld = ld; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        waited = 0;
        @(negedge CLK);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        a_before = alu_a; b_before = alu_b; sel_before = alu_sel;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        if (ld) begin
            e.rd = rd; e.data = imm; e.zero = (imm == 32'd0);
            chk("ld_keeps_alu_a", alu_a, a_before);
            chk("ld_keeps_alu_sel", {29'd0, alu_sel}, {29'd0, sel_before});
        end else begin
            ea = rf_m[rs1]; eb = rf_m[rs2];
            r = alu_fn(op, ea, eb);
            e.rd = rd; e.data = r; e.zero = (r == 32'd0);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_sel", {29'd0, alu_sel}, {29'd0, op});
        end
        if (rd != 3'd0) rf_m[rd] = e.data;
        expq.push_back(e);
        if (b_before === 32'hx) chk("alu_b_known", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_res_data", res_data, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        @(posedge CLK); #1;

        // back-to-back loads, one per cycle
        send(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 32'd5, w);
        chk("ld1_wait", w, 32'd0);
        send(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 32'd3, w);
        chk("ld2_wait", w, 32'd0);

        send(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2, 32'd0, w);
        @(negedge CLK); chk("exec_not_ready", {31'd0, in_ready}, 32'd0);
        @(negedge CLK); chk("wb_not_ready", {31'd0, in_ready}, 32'd0);
        @(negedge CLK); chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("add_strobe", {31'd0, res_valid}, 32'd1);
        @(posedge CLK); #1;

        send(1'b0, OP_SUB, 3'd4, 3'd2, 3'd1, 32'd0, w);
        send(1'b0, OP_SLT, 3'd5, 3'd2, 3'd1, 32'd0, w);
        chk("held_valid_wait", w, 32'd2);
        send(1'b0, OP_AND, 3'd6, 3'd1, 3'd2, 32'd0, w);
        send(1'b1, OP_ADD, 3'd7, 3'd0, 3'd0, 32'h0F0, w);
        send(1'b0, OP_AND, 3'd6, 3'd7, 3'd2, 32'd0, w);
        send(1'b1, OP_ADD, 3'd0, 3'd0, 3'd0, 32'hDEAD, w);
        send(1'b0, OP_ADD, 3'd1, 3'd0, 3'd0, 32'd0, w);
        send(1'b0, 3'b110, 3'd2, 3'd3, 3'd4, 32'd0, w);
        send(1'b0, OP_MUL, 3'd3, 3'd4, 3'd4, 32'd0, w);
        send(1'b0, OP_ADD, 3'd4, 3'd3, 3'd5, 32'd0, w);
        repeat (4) @(posedge CLK);
        #1;

        // reset while an ALU op is in EXEC: nothing may be reported
        send(1'b0, OP_OR, 3'd5, 3'd3, 3'd4, 32'd0, w);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("post_reset_ready", {31'd0, in_ready}, 32'd1);
        chk("post_reset_res_data", res_data, 32'd0);
        chk("post_reset_alu_sel", {29'd0, alu_sel}, 32'd0);
        repeat (5) @(negedge CLK);
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) send(1'b0, OP_ADD, 3'd0, 3'(i), 3'd0, 32'd0, w);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            logic        ld;
            logic [31:0] imm;
            ld  = ($urandom_range(0, 2) == 0);
            imm = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            send(ld, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), imm, w);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end
        end

        repeat (6) @(posedge CLK);
        #1;
        chk("all_results_seen", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
